enemy_collision_detect: RTL

ENEMY_COLLISION_DETECT -- requirements
Module: enemy_collision_detect

---
 rtl/enemies_struct.sv | 13 +
 rtl/enemy_collision_detect.sv | 120 ++++++++++++
 2 files changed

// File: rtl/enemies_struct.sv
// Shared type definitions for the enemy subsystem.
// coll_state_t encodes the collision detector's frame-level progress.
package enemies_struct;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StHit,
        StReport,
        StCooldown
    } coll_state_t;

endpackage

// File: rtl/enemy_collision_detect.sv
// Detects the first enemy/bullet pixel overlap in a frame and reports it as a
// one-cycle strobe just after the following frame start, then skips a few frames.
module enemy_collision_detect
    import enemies_struct::*;
#(
    parameter int unsigned X_MAX           = 640,
    parameter int unsigned Y_MAX           = 475,
    parameter int unsigned COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lcd_xpos,
    input  logic [11:0] lcd_ypos,
    input  logic        enable,
    input  logic        freeze,
    input  logic        enemy_pixel_valid,
    input  logic        bullet_pixel_valid,
    output logic [11:0] killed_enemy_x,
    output logic [11:0] killed_enemy_y,
    output logic        valid_enemy_collision,
    output logic        bullet_hit,
    output logic [7:0]  hit_count
);

    localparam logic [11:0] XMaxW  = 12'(X_MAX);
    localparam logic [11:0] YMaxW  = 12'(Y_MAX);
    localparam logic [3:0]  CdLoad = 4'(COOLDOWN_FRAMES);

    coll_state_t state_q, state_d;
    logic [11:0] kill_x_q, kill_x_d;
    logic [11:0] kill_y_q, kill_y_d;
    logic [3:0]  cd_cnt_q, cd_cnt_d;
    logic [7:0]  hits_q, hits_d;
    logic        strobe_q, strobe_d;

    logic frame_start;
    logic overlap;

    assign frame_start = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
    assign overlap     = enemy_pixel_valid && bullet_pixel_valid &&
                         (lcd_xpos < XMaxW) && (lcd_ypos < YMaxW);

    always_comb begin
        state_d  = state_q;
        kill_x_d = kill_x_q;
        kill_y_d = kill_y_q;
        cd_cnt_d = cd_cnt_q;
        hits_d   = hits_q;
        strobe_d = 1'b0;

        // Disabling wins over freeze; coordinates and hit count survive.
        if (!enable) begin
            state_d = StIdle;
        end else if (!freeze) begin
            case (state_q)
                StIdle: begin
                    if (frame_start) state_d = StScan;
                end
                StScan: begin
                    if (overlap) begin
                        kill_x_d = lcd_xpos;
                        kill_y_d = lcd_ypos;
                        state_d  = StHit;
                    end
                end
                StHit: begin
                    if (frame_start) begin
                        state_d  = StReport;
                        strobe_d = 1'b1;
                        if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                    end
                end
                StReport: begin
                    if (CdLoad == 4'd0) begin
                        state_d = StScan;
                    end else begin
                        state_d  = StCooldown;
                        cd_cnt_d = CdLoad;
                    end
                end
                StCooldown: begin
                    if (frame_start) begin
                        if (cd_cnt_q <= 4'd1) begin
                            state_d  = StScan;
                            cd_cnt_d = 4'd0;
                        end else begin
                            cd_cnt_d = cd_cnt_q - 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            kill_x_q <= '0;
            kill_y_q <= '0;
            cd_cnt_q <= '0;
            hits_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kill_x_q <= kill_x_d;
            kill_y_q <= kill_y_d;
            cd_cnt_q <= cd_cnt_d;
            hits_q   <= hits_d;
            strobe_q <= strobe_d;
        end
    end

    assign killed_enemy_x        = kill_x_q;
    assign killed_enemy_y        = kill_y_q;
    assign valid_enemy_collision = strobe_q;
    assign bullet_hit            = strobe_q;
    assign hit_count             = hits_q;

endmodule
